game_sequencer: RTL and testbench

Turn and board-memory sequencer for the game datapath. It sits between the menu block (`is_game_on`, `board_size`), the mouse cell decoder and the board RAM. It clears the board at game start, turns validated mouse clicks into read-check-write transactions on the board RAM, and alternates players. It also detects a full board and returns control to the menu.

---
 rtl/game_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Turn and board-memory sequencer: clears the board RAM at game start, turns accepted
// clicks into read-check-write moves, alternates players and reports a full board.
module game_sequencer #(
  parameter int MAX_SIZE = 4,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_game_on,
  input  logic [2:0]        board_size,
  input  logic              click,
  input  logic              cell_valid,
  input  logic [1:0]        cell_x,
  input  logic [1:0]        cell_y,
  input  logic [1:0]        rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_wdata,
  output logic              player,
  output logic [4:0]        moves,
  output logic              busy,
  output logic              game_over,
  output logic              menu_rst
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PLAY  = 3'd2,
    ST_READ  = 3'd3,
    ST_CHECK = 3'd4,
    ST_WRITE = 3'd5,
    ST_OVER  = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(MAX_SIZE * MAX_SIZE - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(MAX_SIZE);
  localparam logic [1:0]        CELL_EMPTY = 2'b00;

  function automatic logic [1:0] mark_code(input logic who);
    logic [1:0] code;
    if (who) begin
      code = 2'b10;
    end else begin
      code = 2'b01;
    end
    return code;
  endfunction

  state_t            state_r, state_s;
  logic [2:0]        size_r, size_s;
  logic [ADDR_W-1:0] clr_idx_r, clr_idx_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              player_r, player_s;
  logic [4:0]        moves_r, moves_s;
  logic              menu_rst_s;
  logic [4:0]        size_sq_s;
  logic              hit_s;
  logic              abort_s;

  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mem_we_r, mem_we_s;
  logic [1:0]        mem_wdata_r, mem_wdata_s;
  logic              busy_r, busy_s;
  logic              game_over_r, game_over_s;
  logic              menu_rst_r;

  // Move acceptance, board-area product and abort qualifier
  always_comb begin
    size_sq_s = {2'b00, size_r} * {2'b00, size_r};
    hit_s     = click & cell_valid & ({1'b0, cell_x} < size_r) & ({1'b0, cell_y} < size_r);
    abort_s   = ~is_game_on & (state_r != ST_IDLE);
  end

  // Next-state and datapath update
  always_comb begin
    state_s    = state_r;
    size_s     = size_r;
    clr_idx_s  = clr_idx_r;
    addr_s     = addr_r;
    player_s   = player_r;
    moves_s    = moves_r;
    menu_rst_s = 1'b0;
    if (abort_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_game_on) begin
            state_s   = ST_CLEAR;
            size_s    = board_size;
            clr_idx_s = '0;
            player_s  = 1'b0;
            moves_s   = 5'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          // Every RAM cell is wiped, not just the active N x N corner
          clr_idx_s = clr_idx_r + 1'b1;
          if (clr_idx_r == LAST_IDX) begin
            state_s = ST_PLAY;
          end else begin
            state_s = ST_CLEAR;
          end
        end
        ST_PLAY: begin
          if (hit_s) begin
            state_s = ST_READ;
            addr_s  = ADDR_W'(cell_y) * ROW_STRIDE + ADDR_W'(cell_x);
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_READ: begin
          state_s = ST_CHECK;
        end
        ST_CHECK: begin
          if (rd_data != CELL_EMPTY) begin
            state_s = ST_PLAY;
          end else begin
            state_s = ST_WRITE;
          end
        end
        ST_WRITE: begin
          player_s = ~player_r;
          moves_s  = moves_r + 5'd1;
          if ((moves_r + 5'd1) == size_sq_s) begin
            state_s = ST_OVER;
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_OVER: begin
          if (click) begin
            state_s    = ST_IDLE;
            menu_rst_s = 1'b1;
          end else begin
            state_s = ST_OVER;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so outputs come straight from flops
  always_comb begin
    mem_we_s    = 1'b0;
    mem_wdata_s = CELL_EMPTY;
    mem_addr_s  = addr_s;
    case (state_s)
      ST_CLEAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = clr_idx_s;
      end
      ST_WRITE: begin
        mem_we_s    = 1'b1;
        mem_wdata_s = mark_code(player_s);
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
    busy_s      = (state_s == ST_CLEAR) || (state_s == ST_READ) ||
                  (state_s == ST_CHECK) || (state_s == ST_WRITE);
    game_over_s = (state_s == ST_OVER);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      size_r      <= 3'd0;
      clr_idx_r   <= '0;
      addr_r      <= '0;
      player_r    <= 1'b0;
      moves_r     <= 5'd0;
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 2'b00;
      busy_r      <= 1'b0;
      game_over_r <= 1'b0;
      menu_rst_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      size_r      <= size_s;
      clr_idx_r   <= clr_idx_s;
      addr_r      <= addr_s;
      player_r    <= player_s;
      moves_r     <= moves_s;
      mem_addr_r  <= mem_addr_s;
      mem_we_r    <= mem_we_s;
      mem_wdata_r <= mem_wdata_s;
      busy_r      <= busy_s;
      game_over_r <= game_over_s;
      menu_rst_r  <= menu_rst_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign player    = player_r;
  assign moves     = moves_r;
  assign busy      = busy_r;
  assign game_over = game_over_r;
  assign menu_rst  = menu_rst_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: board RAM model, event-level reference model compared
// every cycle, directed scenarios with literal expectations, then random play.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       is_game_on;
  logic [2:0] board_size;
  logic       click;
  logic       cell_valid;
  logic [1:0] cell_x;
  logic [1:0] cell_y;
  logic [1:0] rd_data;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic       player;
  logic [4:0] moves;
  logic       busy;
  logic       game_over;
  logic       menu_rst;

  game_sequencer #(.MAX_SIZE(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .is_game_on(is_game_on), .board_size(board_size),
    .click(click), .cell_valid(cell_valid), .cell_x(cell_x), .cell_y(cell_y),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .player(player), .moves(moves), .busy(busy), .game_over(game_over),
    .menu_rst(menu_rst)
  );

  always #5 clk = ~clk;

  // Board RAM: synchronous write, registered read
  logic [1:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_data <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: game phase plus a step counter within a move
  localparam int M_IDLE = 0, M_CLEAR = 1, M_PLAY = 2, M_MOVE = 3, M_OVER = 4;
  int m_mode = M_IDLE, m_cnt = 0, m_size = 0, m_hold = 0, m_player = 0, m_moves = 0;
  int m_board [16];
  int e_addr = 0, e_we = 0, e_wdata = 0, e_busy = 0, e_over = 0, e_menu = 0;

  task automatic model_step();
    if (e_we != 0) m_board[e_addr] = e_wdata;
    e_menu = 0;
    if (rst) begin
      m_mode = M_IDLE; m_player = 0; m_moves = 0; m_hold = 0;
    end else if (m_mode != M_IDLE && !is_game_on) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (is_game_on) begin
          m_size = int'(board_size); m_player = 0; m_moves = 0; m_cnt = 0; m_mode = M_CLEAR;
        end
        M_CLEAR: begin
          m_cnt++;
          if (m_cnt == 16) m_mode = M_PLAY;
        end
        M_PLAY: if (click && cell_valid && int'(cell_x) < m_size && int'(cell_y) < m_size) begin
          m_hold = int'(cell_y) * 4 + int'(cell_x); m_mode = M_MOVE; m_cnt = 0;
        end
        M_MOVE: begin
          if (m_cnt == 0) m_cnt = 1;
          else if (m_cnt == 1) begin
            if (m_board[m_hold] != 0) m_mode = M_PLAY;
            else m_cnt = 2;
          end else begin
            m_player ^= 1; m_moves++;
            m_mode = (m_moves == m_size * m_size) ? M_OVER : M_PLAY;
          end
        end
        M_OVER: if (click) begin
          e_menu = 1; m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    e_we    = (m_mode == M_CLEAR || (m_mode == M_MOVE && m_cnt == 2)) ? 1 : 0;
    e_addr  = (m_mode == M_CLEAR) ? m_cnt : m_hold;
    e_wdata = (m_mode == M_MOVE && m_cnt == 2) ? (m_player != 0 ? 2 : 1) : 0;
    e_busy  = (m_mode == M_CLEAR || m_mode == M_MOVE) ? 1 : 0;
    e_over  = (m_mode == M_OVER) ? 1 : 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_addr", int'(mem_addr), e_addr);
      chk("mem_we", int'(mem_we), e_we);
      chk("mem_wdata", int'(mem_wdata), e_wdata);
      chk("player", int'(player), m_player);
      chk("moves", int'(moves), m_moves);
      chk("busy", int'(busy), e_busy);
      chk("game_over", int'(game_over), e_over);
      chk("menu_rst", int'(menu_rst), e_menu);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a click for one cycle; returns at the negedge of cycle t+1
  task automatic click_at(input int x, input int y, input logic v);
    click = 1'b1; cell_x = 2'(x); cell_y = 2'(y); cell_valid = v;
    @(negedge clk);
    click = 1'b0; cell_valid = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; is_game_on = 1'b0; board_size = 3'd3; click = 1'b0;
    cell_valid = 1'b1; cell_x = 2'd0; cell_y = 2'd0;
    cycles(2);
    chk_en = 1'b1;
    chk("reset_mem_we", int'(mem_we), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_moves", int'(moves), 0);
    chk("reset_game_over", int'(game_over), 0);
    rst = 1'b0;

    // Game on, N=3: sixteen clear writes, size change during clear ignored
    is_game_on = 1'b1; board_size = 3'd3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) board_size = 3'd2;
      chk("clear_we", int'(mem_we), 1);
      chk("clear_addr", int'(mem_addr), i);
      chk("clear_busy", int'(busy), 1);
    end
    @(negedge clk);
    chk("play_busy", int'(busy), 0);

    click_at(1, 2, 1'b1);
    chk("read_addr", int'(mem_addr), 9);
    cycles(2);
    chk("write_we", int'(mem_we), 1);
    chk("write_addr", int'(mem_addr), 9);
    chk("write_data", int'(mem_wdata), 1);
    cycles(1);
    chk("move1_player", int'(player), 1);
    chk("move1_moves", int'(moves), 1);

    // Occupied cell: back in PLAY at t+3 with nothing written
    click_at(1, 2, 1'b1);
    cycles(2);
    chk("occ_busy", int'(busy), 0);
    chk("occ_we", int'(mem_we), 0);
    chk("occ_moves", int'(moves), 1);

    click_at(3, 0, 1'b1);
    chk("x_oob_busy", int'(busy), 0);
    chk("x_oob_addr", int'(mem_addr), 9);
    click_at(1, 1, 1'b0);
    chk("invalid_busy", int'(busy), 0);

    click_at(0, 0, 1'b1);
    click_at(2, 2, 1'b1);
    cycles(1);
    chk("move2_data", int'(mem_wdata), 2);
    chk("move2_addr", int'(mem_addr), 0);
    cycles(1);
    chk("move2_moves", int'(moves), 2);
    cycles(1);
    chk("no_queue_busy", int'(busy), 0);

    // N=2 full game
    is_game_on = 1'b0;
    cycles(1);
    is_game_on = 1'b1; board_size = 3'd2;
    cycles(17);
    for (int k = 0; k < 4; k++) begin
      click_at(k % 2, k / 2, 1'b1);
      cycles(2);
      chk("n2_data", int'(mem_wdata), (k % 2 == 0) ? 1 : 2);
      cycles(1);
      chk("n2_moves", int'(moves), k + 1);
    end
    chk("n2_over", int'(game_over), 1);
    click_at(3, 3, 1'b0);
    chk("menu_rst_hi", int'(menu_rst), 1);
    chk("menu_over_lo", int'(game_over), 0);
    is_game_on = 1'b0;
    cycles(1);
    chk("menu_rst_lo", int'(menu_rst), 0);

    // Abort on the fifth clear cycle
    is_game_on = 1'b1; board_size = 3'd4;
    cycles(5);
    is_game_on = 1'b0;
    cycles(1);
    chk("abort_we", int'(mem_we), 0);
    chk("abort_busy", int'(busy), 0);

    // Random play against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (!is_game_on) is_game_on = ($urandom_range(0, 3) == 0);
      else is_game_on = ($urandom_range(0, 299) != 0);
      board_size = 3'($urandom_range(2, 4));
      click = ($urandom_range(0, 2) == 0);
      cell_valid = ($urandom_range(0, 7) != 0);
      cell_x = 2'($urandom_range(0, 3));
      cell_y = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0; click = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
